// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the ex load/store port (m0) and instruction fetch (m1).
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   m0_req/we/addr/wdata_i    ex request (held until m0_gnt_o)
//   m0_gnt/rvalid/rdata/stall ex grant pulse, response pulse + data, stall
//   m1_req/addr_i             fetch request (read only, held until m1_gnt_o)
//   m1_gnt/rvalid/rdata/stall fetch grant pulse, response pulse + data, stall
//   mem_req/we/addr/wdata_o   memory strobe and payload, driven only in the grant cycle
//   mem_rdata_i               memory read data, valid MEM_LAT cycles after mem_req_o
// m0 has fixed priority; after STARVE_N contested m0 grants, m1 wins the next contest.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int STARVE_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_stall_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int SW = $clog2(STARVE_N + 1);
  state_t        state, state_nx;
  logic          owner, owner_nx, wr, wr_nx, pick1, done;
  logic [1:0]    lat, lat_nx;
  logic [SW-1:0] starve, starve_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      wr     <= 1'b0;
      lat    <= 2'd0;
      starve <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      wr     <= wr_nx;
      lat    <= lat_nx;
      starve <= starve_nx;
    end
  // outputs are gated by rst so everything reads 0 while reset is held
  always_comb begin
    pick1       = m1_req_i & (~m0_req_i | starve == SW'(STARVE_N));
    m0_gnt_o    = rst & state == IDLE & m0_req_i & ~pick1;
    m1_gnt_o    = rst & state == IDLE & pick1;
    done        = rst & state == WAIT & lat == 2'd0;
    mem_req_o   = m0_gnt_o | m1_gnt_o;
    mem_we_o    = m0_gnt_o & m0_we_i;
    mem_addr_o  = m0_gnt_o ? m0_addr_i : m1_gnt_o ? m1_addr_i : '0;
    mem_wdata_o = mem_we_o ? m0_wdata_i : '0;
    m0_rvalid_o = done & ~owner;
    m1_rvalid_o = done & owner;
    m0_rdata_o  = m0_rvalid_o & ~wr ? mem_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    m0_stall_o  = rst & m0_req_i & ~m0_gnt_o;
    m1_stall_o  = rst & m1_req_i & ~m1_gnt_o;
    state_nx    = mem_req_o ? WAIT : done ? IDLE : state;
    owner_nx    = mem_req_o ? m1_gnt_o : owner;
    wr_nx       = mem_req_o ? mem_we_o : wr;
    lat_nx      = mem_req_o ? 2'(MEM_LAT - 1) : (state == WAIT && lat != 2'd0) ? lat - 2'd1 : lat;
    // only grants made while m1 is waiting count towards starvation
    starve_nx   = m1_gnt_o ? '0 :
                  (m0_gnt_o & m1_req_i & starve != SW'(STARVE_N)) ? starve + SW'(1) : starve;
  end
endmodule
